// File: rtl/demux_key.sv
// Key-routed demultiplexer: one valid/ready input stream is steered into per-port
// one-entry holding registers; beats with an out-of-range key are counted and dropped.
module demux_key #(
    parameter int unsigned NR_OUT   = 4,
    parameter int unsigned KEY_LEN  = 2,
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned CNT_LEN  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KEY_LEN-1:0]           in_key,
    input  logic [DATA_LEN-1:0]          in_data,
    output logic [NR_OUT-1:0]            out_valid,
    input  logic [NR_OUT-1:0]            out_ready,
    output logic [NR_OUT*DATA_LEN-1:0]   out_data,
    output logic                         drop_err,
    output logic [CNT_LEN-1:0]           drop_cnt
);

    typedef enum logic {StEmpty, StFull} port_state_t;

    // One extra bit so NR_OUT == 2**KEY_LEN is representable.
    localparam logic [KEY_LEN:0]   NrOutW = (KEY_LEN + 1)'(NR_OUT);
    localparam logic [CNT_LEN-1:0] CntMax = '1;

    port_state_t         state_q [NR_OUT];
    port_state_t         state_d [NR_OUT];
    logic [DATA_LEN-1:0] data_q  [NR_OUT];
    logic [NR_OUT-1:0]   load;
    logic [NR_OUT-1:0]   drain;
    logic                key_ok;
    logic                accept;
    logic                drop;
    logic                drop_err_q;
    logic [CNT_LEN-1:0]  drop_cnt_q;

    assign key_ok = {1'b0, in_key} < NrOutW;

    // Handshake and routing decode; invalid keys match no port so in_ready stays 1.
    always_comb begin
        in_ready = 1'b1;
        load     = '0;
        drain    = '0;
        for (int i = 0; i < NR_OUT; i++) begin
            drain[i] = (state_q[i] == StFull) & out_ready[i];
            if (in_key == KEY_LEN'(i)) begin
                in_ready = (state_q[i] == StEmpty) | out_ready[i];
            end
        end
        accept = in_valid & in_ready;
        for (int i = 0; i < NR_OUT; i++) begin
            load[i] = accept & key_ok & (in_key == KEY_LEN'(i));
        end
        drop = accept & ~key_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_OUT; i++) begin
                state_q[i] <= StEmpty;
                data_q[i]  <= '0;
            end
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NR_OUT; i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
            drop_err_q <= drop;
            if (drop && (drop_cnt_q != CntMax)) begin
                drop_cnt_q <= drop_cnt_q + CNT_LEN'(1);
            end
        end
    end

    // A load wins over a drain: simultaneous drain and refill keeps the port full.
    always_comb begin
        for (int i = 0; i < NR_OUT; i++) begin
            state_d[i] = state_q[i];
            if (load[i]) begin
                state_d[i] = StFull;
            end else if (drain[i]) begin
                state_d[i] = StEmpty;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < NR_OUT; i++) begin
            out_valid[i]                      = (state_q[i] == StFull);
            out_data[DATA_LEN*i +: DATA_LEN] = data_q[i];
        end
        drop_err = drop_err_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_demux_key.sv
// Bench for demux_key: a 4-port instance and a 3-port instance with a 2-bit drop counter,
// checked against a per-port queue model plus hand-derived vectors.
module tb_demux_key;

    logic       clk;
    logic       rst;
    logic       iv   [2];
    logic [1:0] ik   [2];
    logic [7:0] id   [2];
    logic [3:0] ordy [2];

    logic        rdy0, err0;
    logic [3:0]  ov0;
    logic [31:0] od0;
    logic [7:0]  cnt0;
    logic        rdy1, err1;
    logic [2:0]  ov1;
    logic [23:0] od1;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model: per-DUT port occupancy, port contents, drop flag and counter.
    bit         mv   [2][4];
    logic [7:0] md   [2][4];
    bit         merr [2];
    int         mcnt [2];
    int         nr   [2] = '{4, 3};
    int         cmax [2] = '{255, 3};

    demux_key u_dut (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(rdy0), .in_key(ik[0]), .in_data(id[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
        .drop_err(err0), .drop_cnt(cnt0)
    );

    demux_key #(.NR_OUT(3), .KEY_LEN(2), .DATA_LEN(8), .CNT_LEN(2)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(rdy1), .in_key(ik[1]), .in_data(id[1]),
        .out_valid(ov1), .out_ready(ordy[1][2:0]), .out_data(od1),
        .drop_err(err1), .drop_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                mv[d][i] = 1'b0;
                md[d][i] = 8'h00;
            end
            merr[d] = 1'b0;
            mcnt[d] = 0;
        end
    endtask

    function automatic bit m_ready(input int d);
        int k = int'(ik[d]);
        if (k >= nr[d]) return 1'b1;
        return !mv[d][k] || ordy[d][k];
    endfunction

    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit acc = iv[d] && m_ready(d);
            int k   = int'(ik[d]);
            for (int i = 0; i < nr[d]; i++) begin
                if (mv[d][i] && ordy[d][i]) mv[d][i] = 1'b0;
            end
            merr[d] = 1'b0;
            if (acc && k < nr[d]) begin
                mv[d][k] = 1'b1;
                md[d][k] = id[d];
            end else if (acc) begin
                merr[d] = 1'b1;
                if (mcnt[d] < cmax[d]) mcnt[d]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [3:0] ev = '0;
            logic [3:0] av = (d == 0) ? ov0 : {1'b0, ov1};
            for (int i = 0; i < nr[d]; i++) ev[i] = mv[d][i];
            check($sformatf("d%0d in_ready key%0d", d, ik[d]),
                  32'((d == 0) ? rdy0 : rdy1), 32'(m_ready(d)));
            check($sformatf("d%0d out_valid", d), 32'(av), 32'(ev));
            for (int i = 0; i < nr[d]; i++) begin
                logic [7:0] s = (d == 0) ? od0[8*i +: 8] : od1[8*i +: 8];
                check($sformatf("d%0d out_data[%0d]", d, i), 32'(s), 32'(md[d][i]));
            end
            check($sformatf("d%0d drop_err", d), 32'((d == 0) ? err0 : err1), 32'(merr[d]));
            check($sformatf("d%0d drop_cnt", d),
                  (d == 0) ? 32'(cnt0) : 32'(cnt1), 32'(mcnt[d]));
        end
    endtask

    // Inputs are set just after a posedge; compare before the next edge, then advance.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            ik[d]   = 2'd0;
            id[d]   = 8'h00;
            ordy[d] = 4'h0;
        end
    endtask

    typedef struct {
        bit         v;
        logic [1:0] k;
        logic [7:0] d;
        logic [3:0] rdy;
        bit         exp_rdy;
        logic [3:0] exp_ov;
        int         idx;
        logic [7:0] exp_slice;
    } vec_t;

    vec_t tbl [13];
    int   sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 2, 8'hA5};
        tbl[1]  = '{1'b1, 2'd0, 8'h11, 4'hF, 1'b1, 4'b0001, 0, 8'h11};
        tbl[2]  = '{1'b1, 2'd1, 8'h22, 4'hF, 1'b1, 4'b0010, 1, 8'h22};
        tbl[3]  = '{1'b1, 2'd3, 8'h33, 4'hF, 1'b1, 4'b1000, 3, 8'h33};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 3, 8'h33};
        tbl[5]  = '{1'b1, 2'd1, 8'h5A, 4'h0, 1'b1, 4'b0010, 1, 8'h5A};
        tbl[6]  = '{1'b1, 2'd1, 8'h77, 4'h0, 1'b0, 4'b0010, 1, 8'h5A};
        tbl[7]  = '{1'b1, 2'd3, 8'hC3, 4'h0, 1'b1, 4'b1010, 3, 8'hC3};
        tbl[8]  = '{1'b1, 2'd1, 8'h77, 4'h2, 1'b1, 4'b1010, 1, 8'h77};
        tbl[9]  = '{1'b0, 2'd1, 8'h00, 4'hF, 1'b1, 4'b0000, 1, 8'h77};
        tbl[10] = '{1'b1, 2'd0, 8'h01, 4'h0, 1'b1, 4'b0001, 0, 8'h01};
        tbl[11] = '{1'b1, 2'd0, 8'h02, 4'h1, 1'b1, 4'b0001, 0, 8'h02};
        tbl[12] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 0, 8'h02};

        model_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ik[0] = 2'(k);
            ik[1] = 2'(k);
            #1;
            check($sformatf("idle in_ready d0 key%0d", k), 32'(rdy0), 32'd1);
            check($sformatf("idle in_ready d1 key%0d", k), 32'(rdy1), 32'd1);
        end
        ik[0] = 2'd0;
        ik[1] = 2'd0;
        step();

        for (int n = 0; n < 13; n++) begin
            iv[0]   = tbl[n].v;
            ik[0]   = tbl[n].k;
            id[0]   = tbl[n].d;
            ordy[0] = tbl[n].rdy;
            #1;
            check($sformatf("vec%0d in_ready", n), 32'(rdy0), 32'(tbl[n].exp_rdy));
            step();
            check($sformatf("vec%0d out_valid", n), 32'(ov0), 32'(tbl[n].exp_ov));
            check($sformatf("vec%0d slice%0d", n, tbl[n].idx),
                  32'(od0[8*tbl[n].idx +: 8]), 32'(tbl[n].exp_slice));
        end
        idle_inputs();

        iv[1] = 1'b1;
        ik[1] = 2'd3;
        for (int j = 0; j < 5; j++) begin
            id[1] = 8'(j);
            step();
            check($sformatf("sat drop_err beat%0d", j), 32'(err1), 32'd1);
            check($sformatf("sat drop_cnt beat%0d", j), 32'(cnt1), 32'(sat_exp[j]));
            check($sformatf("sat out_valid beat%0d", j), 32'(ov1), 32'd0);
        end
        iv[1] = 1'b0;
        step();
        check("sat drop_err after", 32'(err1), 32'd0);

        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d]   = ($urandom_range(0, 3) != 0);
                ik[d]   = 2'($urandom_range(0, 3));
                id[d]   = 8'($urandom);
                ordy[d] = 4'($urandom);
            end
            step();
        end

        idle_inputs();
        step();
        iv[0] = 1'b1; ik[0] = 2'd0; id[0] = 8'h3C;
        iv[1] = 1'b1; ik[1] = 2'd3;
        step();
        ik[0] = 2'd2; id[0] = 8'hC3;
        step();
        idle_inputs();
        #1;
        check("pre-reset out_valid", 32'(ov0), 32'b0101);
        #1;
        rst = 1'b0;
        #1;
        check("async out_valid d0", 32'(ov0), 32'd0);
        check("async drop_cnt d0", 32'(cnt0), 32'd0);
        check("async out_valid d1", 32'(ov1), 32'd0);
        check("async drop_cnt d1", 32'(cnt1), 32'd0);
        check("async out_data d0", od0, 32'd0);
        model_reset();
        repeat (3) step();
        rst = 1'b1;
        ordy[0] = 4'hF;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_key.md
Name: demux_key

Overview:
- Registered key-routed demultiplexer: the counterpart of the key-select mux. It takes one input stream (key + data) with a valid/ready handshake and delivers each beat to the output port whose index equals the key.
- Each output port owns a one-entry holding register with its own valid/ready handshake, so slow consumers stall only traffic addressed to them.
- Sits between an NVBoard-facing source (switch/keyboard sampler) and several downstream consumers (LED, seven-segment, register blocks).

Parameters:
NR_OUT, 4, number of output ports; must satisfy 2 <= NR_OUT <= 2**KEY_LEN
KEY_LEN, 2, key width in bits
DATA_LEN, 8, payload width in bits
CNT_LEN, 8, width of the dropped-beat counter

Ports:
clk  input  1  sole clock, all state updates on posedge
rst  input  1  asynchronous reset, active-low (asserted when 0)
in_valid  input  1  input beat present
in_ready  output  1  block accepts the beat this cycle
in_key  input  KEY_LEN  destination port index
in_data  input  DATA_LEN  payload
out_valid  output  NR_OUT  bit i: port i holding register full
out_ready  input  NR_OUT  bit i: consumer i takes the beat this cycle
out_data  output  NR_OUT*DATA_LEN  port i occupies bits [DATA_LEN*(i+1)-1 : DATA_LEN*i]
drop_err  output  1  one-cycle pulse when a beat with key >= NR_OUT is accepted
drop_cnt  output  CNT_LEN  saturating count of dropped beats

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, drop_err=0, drop_cnt=0. All registers are held while rst=0. Release is synchronous to clk.
- Handshake: an input transfer occurs when in_valid & in_ready on a posedge. Port i transfers when out_valid[i] & out_ready[i].
- in_ready is combinational from state and out_ready:
  - key < NR_OUT: in_ready = ~out_valid[key] | out_ready[key] (pass-through refill allowed).
  - key >= NR_OUT: in_ready = 1.
  - in_ready does not depend on in_valid.
- Routing, key k < NR_OUT, on input transfer: the port k register loads in_data and out_valid[k] is 1 the next cycle. Latency is 1 cycle from accept to out_valid.
- Per-port state, two states, EMPTY and FULL:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on an output transfer with no load.
  - FULL -> FULL with new data when an output transfer and a load happen in the same cycle. The consumer sees the old data on that edge and the new data afterwards.
- Data stability: while out_valid[i]=1 and out_ready[i]=0, out_data slice i holds. out_data slice i is not cleared when the port empties; it keeps its last value.
- Independence: a stalled port never blocks a beat addressed to a different port. Several ports may drain in the same cycle. At most one port loads per cycle.
- Invalid key (k >= NR_OUT):
  - The beat is accepted and discarded; no port changes.
  - drop_err = 1 for exactly the next cycle.
  - drop_cnt increments by 1 and saturates at 2**CNT_LEN-1, with no wrap.
  - Back-to-back invalid beats hold drop_err high continuously.
- Arithmetic: the key is compared unsigned at the full KEY_LEN width. When NR_OUT = 2**KEY_LEN, no key is invalid and drop_err never fires.
- Reset mid-operation: pending port data is lost and the counter is cleared. No beat is delivered after reset unless a new input transfer occurs.
- The block does not depend on in_key or in_data being stable while in_valid=0.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> out_valid=0000, drop_cnt=0, drop_err=0, in_ready=1 for every key.
- Basic routing: out_ready=1111; send (key=2, data=8'hA5) -> next cycle out_valid=0100 and out_data[23:16]=8'hA5. Then send keys 0,1,3 with data 8'h11, 8'h22, 8'h33 on consecutive cycles -> each appears one cycle later on its own slice.
- Backpressure and independence: out_ready=0000; send key=1, data=8'h5A -> out_valid[1]=1. A second key=1 beat sees in_ready=0 and data stays 8'h5A. A key=3 beat is still accepted. Raise out_ready[1] -> the held key=1 beat is accepted the same cycle (pass-through) and slice 1 becomes the new data one cycle later.
- Simultaneous drain and refill: port 0 is FULL with 8'h01 and out_ready[0]=1; send key=0, data=8'h02 -> consumer samples 8'h01 on that edge, then out_valid[0] stays 1 with data 8'h02.
- Invalid key and saturation: NR_OUT=3, KEY_LEN=2, CNT_LEN=2; send key=3 five times -> no out_valid change, drop_err high during those beats, drop_cnt reads 1,2,3,3,3.
- Async reset mid-flight: ports 0 and 2 FULL; pull rst low between clock edges -> out_valid=0000 immediately without waiting for clk, drop_cnt=0.
